board_engine: RTL and testbench
===============================

// Module: board_engine
// PURPOSE
//  Playfield datapath responding to the game-phase FSM. Consumes the 3-bit phase code and
//  answers with full-row flags (shift), falling status (stop) and game-over code (gameOver).
//  Holds the 22x10 board and the active piece; executes spawn, move, lock and row collapse.
//  Sits between the phase FSM and the VGA renderer, which reads board/piece ports.
// PARAMETERS
//  ROWS        22   board rows; row 0 = bottom, rows 20-21 = hidden spawn zone
//  COLS        10   board columns; col 0 = left
//  SPAWN_ROW   18   anchor row (bottom of 4x4 box) for new pieces
//  SPAWN_COL   3    anchor column (left of 4x4 box) for new pieces
// PORTS
//  clk         in   1          system clock
//  reset       in   1          synchronous, active-high
//  phase       in   3          000 CHECK/HALT, 001 MOVE, 010 WRITE, 011 SHIFT, 100 ADD
//  piece_sel   in   3          piece type 0-6 (I,O,T,S,Z,J,L) sampled in ADD; 7 -> treated as 0
//  drop_tick   in   1          gravity strobe, one cycle wide
//  move_left   in   1          shift piece one column left (MOVE only)
//  move_right  in   1          shift piece one column right (MOVE only)
//  shift       out  ROWS       registered full-row flags, bit r = row r full
//  stop        out  ROWS       one-hot anchor row while piece airborne; all-zero once landed
//  gameOver    out  2          00 running, 01 spawn collision, 10 locked in rows 20-21; sticky
//  board       out  ROWS*COLS  settled cells, bit r*COLS+c
//  piece_row   out  5          active piece anchor row
//  piece_col   out  4          active piece anchor column, signed-range 0-9 + mask offsets
//  lines       out  16         cumulative cleared rows, wraps at 65535 -> 0
// BEHAVIOUR
//  Reset: board=0, shift=0, stop=0, gameOver=00, lines=0, piece_row=SPAWN_ROW,
//   piece_col=SPAWN_COL, type=0.
//  Collision fn fits(type,row,col): every mask cell in 0<=r<ROWS, 0<=c<COLS and board cell=0.
//  CHECK: each cycle shift[r] <= &board[r]; one-cycle latency; no board change.
//  SHIFT: on the first cycle of each SHIFT entry, remove lowest r with shift[r]=1:
//   rows r..ROWS-2 take row+1, row ROWS-1 cleared; lines++; shift cleared same edge.
//   shift==0 on entry -> no-op. Exactly one row removed per entry (FSM re-enters via CHECK).
//  ADD: first cycle latches type, anchor=(SPAWN_ROW,SPAWN_COL); if !fits -> gameOver=01
//   and stop=0, else stop=onehot(SPAWN_ROW). Piece never OR'd into board on collision.
//  MOVE: per cycle, lateral first: left&!right and fits(col-1) -> col--; right&!left and
//   fits(col+1) -> col++; both/neither -> no lateral move. Then, if drop_tick: fits(row-1)
//   -> row--, stop=onehot(row-1); else stop=0 (landed). Lateral and drop in same cycle both
//   apply, drop evaluated against post-lateral column.
//  WRITE: first cycle ORs piece mask into board; if any mask cell in rows >=20 -> gameOver=10.
//   stop stays 0. Repeated WRITE cycles are idempotent (OR).
//  gameOver sticky until reset; once nonzero all board/piece updates frozen, shift keeps updating.
//  "First cycle of phase" = phase != phase_q (registered previous phase). reset mid-phase wins
//   over all updates; phase_q resets to 000.
//  Unknown codes 101-111: no state change, outputs hold.
// STRUCTURE
//  tetris_pkg: phase_e enum (codes above), ROWS/COLS, piece_e, go_code_e (00/01/10).
//  Sub-module piece_rom: comb, type[2:0] -> 16-bit 4x4 mask (bit 4*y+x, y=0 bottom), rotation 0.
//  board_engine: board regs, piece regs, fits() comb checker x3 (left/right/down), phase_q.
// TESTING
//  1 reset, ADD piece_sel=1 (O) -> stop=bit18, gameOver=00, piece_col=3.
//  2 MOVE, 18 drop_ticks on empty board -> piece_row 0, 19th tick -> stop=0; WRITE -> board
//    bits rows0-1 cols4-5 set.
//  3 preload rows 0 and 2 full, CHECK -> shift=22'h5 after 1 cycle; SHIFT -> row 0 removed,
//    old row 2 now row 1; CHECK,SHIFT again -> shift=0, lines=2.
//  4 MOVE at col 0 with move_left held 3 cycles -> col unchanged; move_left&move_right -> no move.
//  5 column 4-5 filled to row 19, ADD O -> gameOver=01, board unchanged, stays 01 after more phases.
//  6 reset asserted mid-SHIFT with rows full -> next cycle board=0, lines=0, shift=0.

Source files
------------

// File: rtl/board_engine_pkg.sv
// Shared types, board geometry and collision/stamping helpers for the playfield engine.
package board_engine_pkg;

    localparam int ROWS       = 22;
    localparam int COLS       = 10;
    localparam int SPAWN_ROW  = 18;
    localparam int SPAWN_COL  = 3;
    localparam int HIDDEN_ROW = 20;
    localparam int CELLS      = ROWS * COLS;
    localparam int IDX_W      = $clog2(CELLS);

    typedef enum logic [2:0] {
        PH_CHECK = 3'b000,
        PH_MOVE  = 3'b001,
        PH_WRITE = 3'b010,
        PH_SHIFT = 3'b011,
        PH_ADD   = 3'b100
    } phase_e;

    typedef enum logic [2:0] {
        PC_I = 3'd0,
        PC_O = 3'd1,
        PC_T = 3'd2,
        PC_S = 3'd3,
        PC_Z = 3'd4,
        PC_J = 3'd5,
        PC_L = 3'd6
    } piece_e;

    typedef enum logic [1:0] {
        GO_RUN   = 2'b00,
        GO_SPAWN = 2'b01,
        GO_LOCK  = 2'b10
    } go_code_e;

    // A piece fits when every mask cell lands on the board and on an empty cell.
    function automatic logic fits(input logic [15:0] mask, input logic [4:0] row,
                                  input logic [3:0] col, input logic [CELLS-1:0] brd);
        logic ok;
        int   r;
        int   c;
        ok = 1'b1;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                r = int'(row) + y;
                c = int'(col) + x;
                if (mask[4'(4 * y + x)]) begin
                    if (r >= ROWS || c >= COLS)
                        ok = 1'b0;
                    else if (brd[IDX_W'(r * COLS + c)])
                        ok = 1'b0;
                end
            end
        end
        return ok;
    endfunction

    function automatic logic [CELLS-1:0] stamp(input logic [15:0] mask, input logic [4:0] row,
                                               input logic [3:0] col);
        logic [CELLS-1:0] s;
        int               r;
        int               c;
        s = '0;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                r = int'(row) + y;
                c = int'(col) + x;
                if (mask[4'(4 * y + x)] && r < ROWS && c < COLS)
                    s[IDX_W'(r * COLS + c)] = 1'b1;
            end
        end
        return s;
    endfunction

    function automatic logic touches_hidden(input logic [15:0] mask, input logic [4:0] row);
        logic hit;
        hit = 1'b0;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                if (mask[4'(4 * y + x)] && (int'(row) + y) >= HIDDEN_ROW)
                    hit = 1'b1;
            end
        end
        return hit;
    endfunction

    function automatic logic [ROWS-1:0] row_onehot(input logic [4:0] r);
        logic [ROWS-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    function automatic piece_e spawn_type(input logic [2:0] sel);
        return (sel == 3'd7) ? PC_I : piece_e'(sel);
    endfunction

endpackage

// File: rtl/board_engine_if.sv
// Phase-FSM side (master) to playfield engine (slave) signal bundle.
interface board_engine_if;
    import board_engine_pkg::*;

    logic [2:0]       phase;
    logic [2:0]       piece_sel;
    logic             drop_tick;
    logic             move_left;
    logic             move_right;
    logic [ROWS-1:0]  shift;
    logic [ROWS-1:0]  stop;
    logic [1:0]       gameOver;
    logic [CELLS-1:0] board;
    logic [4:0]       piece_row;
    logic [3:0]       piece_col;
    logic [15:0]      lines;

    modport master (
        output phase, piece_sel, drop_tick, move_left, move_right,
        input  shift, stop, gameOver, board, piece_row, piece_col, lines
    );

    modport slave (
        input  phase, piece_sel, drop_tick, move_left, move_right,
        output shift, stop, gameOver, board, piece_row, piece_col, lines
    );
endinterface

// File: rtl/board_engine_piece_rom.sv
// Piece shape table: rotation-0 4x4 masks, bit 4*y+x with y=0 as the bottom row of the box.
module board_engine_piece_rom
    import board_engine_pkg::*;
(
    input  piece_e      piece,
    output logic [15:0] mask
);
    always_comb begin
        mask = 16'h000F;
        case (piece)
            PC_I:    mask = 16'h000F;
            PC_O:    mask = 16'h0066;
            PC_T:    mask = 16'h0027;
            PC_S:    mask = 16'h0063;
            PC_Z:    mask = 16'h0036;
            PC_J:    mask = 16'h0017;
            PC_L:    mask = 16'h0047;
            default: mask = 16'h000F;
        endcase
    end
endmodule

// File: rtl/board_engine.sv
// Playfield datapath: holds the board and active piece and executes the phase FSM's commands.
module board_engine
    import board_engine_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    board_engine_if.slave bus
);
    logic [CELLS-1:0] board_reg;
    logic [ROWS-1:0]  shift_reg;
    logic [ROWS-1:0]  stop_reg;
    go_code_e         go_reg;
    logic [15:0]      lines_reg;
    logic [4:0]       row_reg;
    logic [3:0]       col_reg;
    piece_e           type_reg;
    logic [2:0]       phase_q_reg;

    logic [15:0]      cur_mask;
    logic [15:0]      new_mask;
    piece_e           new_type;
    logic [ROWS-1:0]  row_full;
    logic [CELLS-1:0] collapsed;
    logic [4:0]       remove_row;
    logic             want_left;
    logic             want_right;
    logic             fit_left;
    logic             fit_right;
    logic             fit_down;
    logic             fit_spawn;
    logic [3:0]       lat_col;
    logic             first_cycle;
    logic             frozen;

    assign new_type    = spawn_type(bus.piece_sel);
    assign first_cycle = (bus.phase != phase_q_reg);
    assign frozen      = (go_reg != GO_RUN);

    board_engine_piece_rom u_rom_cur (
        .piece (type_reg),
        .mask  (cur_mask)
    );

    board_engine_piece_rom u_rom_new (
        .piece (new_type),
        .mask  (new_mask)
    );

    // Row r collapses away: rows below stay, rows above slide down, the top row empties.
    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_rows
            assign row_full[gi] = &board_reg[gi*COLS +: COLS];
            if (gi == ROWS - 1) begin : g_top
                assign collapsed[gi*COLS +: COLS] = '0;
            end else begin : g_body
                assign collapsed[gi*COLS +: COLS] = (5'(gi) < remove_row) ?
                    board_reg[gi*COLS +: COLS] : board_reg[(gi+1)*COLS +: COLS];
            end
        end
    endgenerate

    always_comb begin
        remove_row = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (shift_reg[5'(i)])
                remove_row = 5'(i);
        end
    end

    // Lateral step resolves first; the gravity test uses the post-lateral column.
    always_comb begin
        want_left  = bus.move_left & ~bus.move_right;
        want_right = bus.move_right & ~bus.move_left;
        fit_left   = (col_reg != 4'd0) && fits(cur_mask, row_reg, col_reg - 4'd1, board_reg);
        fit_right  = (col_reg != 4'd15) && fits(cur_mask, row_reg, col_reg + 4'd1, board_reg);
        lat_col    = col_reg;
        if (want_left && fit_left)
            lat_col = col_reg - 4'd1;
        else if (want_right && fit_right)
            lat_col = col_reg + 4'd1;
        fit_down  = (row_reg != 5'd0) && fits(cur_mask, row_reg - 5'd1, lat_col, board_reg);
        fit_spawn = fits(new_mask, 5'(SPAWN_ROW), 4'(SPAWN_COL), board_reg);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            board_reg   <= '0;
            shift_reg   <= '0;
            stop_reg    <= '0;
            go_reg      <= GO_RUN;
            lines_reg   <= '0;
            row_reg     <= 5'(SPAWN_ROW);
            col_reg     <= 4'(SPAWN_COL);
            type_reg    <= PC_I;
            phase_q_reg <= PH_CHECK;
        end else begin
            phase_q_reg <= bus.phase;
            case (bus.phase)
                PH_CHECK: begin
                    shift_reg <= row_full;
                end
                PH_SHIFT: begin
                    if (first_cycle && !frozen && shift_reg != '0) begin
                        board_reg <= collapsed;
                        lines_reg <= lines_reg + 16'd1;
                        shift_reg <= '0;
                    end
                end
                PH_ADD: begin
                    if (first_cycle && !frozen) begin
                        type_reg <= new_type;
                        row_reg  <= 5'(SPAWN_ROW);
                        col_reg  <= 4'(SPAWN_COL);
                        if (fit_spawn) begin
                            stop_reg <= row_onehot(5'(SPAWN_ROW));
                        end else begin
                            stop_reg <= '0;
                            go_reg   <= GO_SPAWN;
                        end
                    end
                end
                PH_MOVE: begin
                    if (!frozen) begin
                        col_reg <= lat_col;
                        if (bus.drop_tick) begin
                            if (fit_down) begin
                                row_reg  <= row_reg - 5'd1;
                                stop_reg <= row_onehot(row_reg - 5'd1);
                            end else begin
                                stop_reg <= '0;
                            end
                        end
                    end
                end
                PH_WRITE: begin
                    if (first_cycle && !frozen) begin
                        board_reg <= board_reg | stamp(cur_mask, row_reg, col_reg);
                        stop_reg  <= '0;
                        if (touches_hidden(cur_mask, row_reg))
                            go_reg <= GO_LOCK;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.shift     = shift_reg;
    assign bus.stop      = stop_reg;
    assign bus.gameOver  = go_reg;
    assign bus.board     = board_reg;
    assign bus.piece_row = row_reg;
    assign bus.piece_col = col_reg;
    assign bus.lines     = lines_reg;

endmodule

// File: tb/tb_board_engine.sv
// Bench for board_engine: directed vector table, hand-built corner sequences, random run vs. cell model.
module tb_board_engine;
    import board_engine_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    board_engine_if bus ();

    board_engine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: board as a 2-D cell grid, pieces as lists of (x,y) cell offsets.
    int px [7][4] = '{'{0,1,2,3}, '{1,2,1,2}, '{0,1,2,1}, '{0,1,1,2}, '{1,2,0,1}, '{0,1,2,0}, '{0,1,2,2}};
    int py [7][4] = '{'{0,0,0,0}, '{0,0,1,1}, '{0,0,0,1}, '{0,0,1,1}, '{0,0,1,1}, '{0,0,0,1}, '{0,0,0,1}};
    bit              mb [ROWS][COLS];
    logic [ROWS-1:0] m_shift;
    logic [ROWS-1:0] m_stop;
    logic [1:0]      m_go;
    logic [15:0]     m_lines;
    int              m_row;
    int              m_col;
    int              m_type;
    logic [2:0]      m_pq;

    function automatic bit m_fits(input int t, input int row, input int col);
        int r;
        int c;
        for (int k = 0; k < 4; k++) begin
            r = row + py[t][k];
            c = col + px[t][k];
            if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return 1'b0;
            if (mb[r][c]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [255:0] m_flat();
        logic [255:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                v[r*COLS + c] = mb[r][c];
        return v;
    endfunction

    function automatic void model_step(input logic rst, input logic [2:0] ph, input logic [2:0] sel,
                                       input logic l, input logic rt, input logic d);
        bit first;
        bit frozen;
        bit full;
        bit hidden;
        int k;
        int t;
        int r;
        int c;
        if (rst) begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++)
                    mb[i][j] = 1'b0;
            m_shift = '0; m_stop = '0; m_go = 2'b00; m_lines = '0;
            m_row = SPAWN_ROW; m_col = SPAWN_COL; m_type = 0; m_pq = 3'b000;
            return;
        end
        first  = (ph != m_pq);
        frozen = (m_go != 2'b00);
        m_pq   = ph;
        case (ph)
            3'b000: begin
                for (int i = 0; i < ROWS; i++) begin
                    full = 1'b1;
                    for (int j = 0; j < COLS; j++)
                        if (!mb[i][j]) full = 1'b0;
                    m_shift[i] = full;
                end
            end
            3'b011: begin
                if (first && !frozen && m_shift != '0) begin
                    k = 0;
                    for (int i = ROWS - 1; i >= 0; i--)
                        if (m_shift[i]) k = i;
                    for (int i = k; i < ROWS - 1; i++)
                        mb[i] = mb[i+1];
                    for (int j = 0; j < COLS; j++)
                        mb[ROWS-1][j] = 1'b0;
                    m_lines = m_lines + 16'd1;
                    m_shift = '0;
                end
            end
            3'b100: begin
                if (first && !frozen) begin
                    t = (sel == 3'd7) ? 0 : int'(sel);
                    m_type = t; m_row = SPAWN_ROW; m_col = SPAWN_COL;
                    if (m_fits(t, m_row, m_col)) begin
                        m_stop = 22'(1) << m_row;
                    end else begin
                        m_stop = '0;
                        m_go   = 2'b01;
                    end
                end
            end
            3'b001: begin
                if (!frozen) begin
                    if (l && !rt && m_col > 0 && m_fits(m_type, m_row, m_col - 1))
                        m_col = m_col - 1;
                    else if (rt && !l && m_col < 15 && m_fits(m_type, m_row, m_col + 1))
                        m_col = m_col + 1;
                    if (d) begin
                        if (m_row > 0 && m_fits(m_type, m_row - 1, m_col)) begin
                            m_row  = m_row - 1;
                            m_stop = 22'(1) << m_row;
                        end else begin
                            m_stop = '0;
                        end
                    end
                end
            end
            3'b010: begin
                if (first && !frozen) begin
                    hidden = 1'b0;
                    for (int q = 0; q < 4; q++) begin
                        r = m_row + py[m_type][q];
                        c = m_col + px[m_type][q];
                        if (r >= HIDDEN_ROW) hidden = 1'b1;
                        if (r < ROWS && c < COLS) mb[r][c] = 1'b1;
                    end
                    m_stop = '0;
                    if (hidden) m_go = 2'b10;
                end
            end
            default: begin
            end
        endcase
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic rst, input logic [2:0] ph, input logic [2:0] sel,
                        input logic l, input logic rt, input logic d);
        reset          = rst;
        bus.phase      = ph;
        bus.piece_sel  = sel;
        bus.move_left  = l;
        bus.move_right = rt;
        bus.drop_tick  = d;
        model_step(rst, ph, sel, l, rt, d);
        @(posedge clk);
        #1;
    endtask

    // Spawn, slide to col, fall to row, lock in place (possibly mid-air), then return to CHECK.
    task automatic place(input int sel, input int col, input int row);
        int n;
        tick(1'b0, PH_ADD, 3'(sel), 1'b0, 1'b0, 1'b0);
        n = (col > SPAWN_COL) ? col - SPAWN_COL : SPAWN_COL - col;
        for (int i = 0; i < n; i++)
            tick(1'b0, PH_MOVE, 3'(sel), col < SPAWN_COL, col > SPAWN_COL, 1'b0);
        for (int i = 0; i < SPAWN_ROW - row; i++)
            tick(1'b0, PH_MOVE, 3'(sel), 1'b0, 1'b0, 1'b1);
        tick(1'b0, PH_WRITE, 3'(sel), 1'b0, 1'b0, 1'b0);
        tick(1'b0, PH_CHECK, 3'(sel), 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic [2:0]  ph;
        logic [2:0]  sel;
        logic        l;
        logic        r;
        logic        d;
        logic [4:0]  row;
        logic [3:0]  col;
        logic [21:0] stop;
        logic [1:0]  go;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] ph, input logic [2:0] sel, input logic l,
                                input logic r, input logic d, input int row, input int col);
        vec_t v;
        v.ph = ph; v.sel = sel; v.l = l; v.r = r; v.d = d;
        v.row = 5'(row); v.col = 4'(col);
        v.stop = 22'(1) << row;
        v.go = 2'b00;
        return v;
    endfunction

    vec_t vecs [25];

    initial begin
        logic [255:0] expb;
        logic [2:0]   cur_ph;
        logic [2:0]   v3;

        vecs[0]  = mk(PH_ADD,   3'd1, 0, 0, 0, 18, 3);
        vecs[1]  = mk(PH_MOVE,  3'd1, 1, 0, 0, 18, 2);
        vecs[2]  = mk(PH_MOVE,  3'd1, 1, 0, 0, 18, 1);
        vecs[3]  = mk(PH_MOVE,  3'd1, 1, 0, 0, 18, 0);
        vecs[4]  = mk(PH_MOVE,  3'd1, 1, 0, 0, 18, 0);
        vecs[5]  = mk(PH_MOVE,  3'd1, 1, 0, 0, 18, 0);
        vecs[6]  = mk(PH_MOVE,  3'd1, 1, 0, 0, 18, 0);
        vecs[7]  = mk(PH_MOVE,  3'd1, 1, 1, 0, 18, 0);
        vecs[8]  = mk(PH_MOVE,  3'd1, 0, 1, 0, 18, 1);
        vecs[9]  = mk(PH_MOVE,  3'd1, 0, 0, 1, 17, 1);
        vecs[10] = mk(PH_MOVE,  3'd1, 0, 1, 1, 16, 2);
        vecs[11] = mk(PH_CHECK, 3'd1, 1, 0, 0, 16, 2);
        vecs[12] = mk(3'd5,     3'd1, 0, 1, 1, 16, 2);
        vecs[13] = mk(PH_MOVE,  3'd1, 0, 1, 0, 16, 3);
        vecs[14] = mk(PH_MOVE,  3'd1, 0, 1, 0, 16, 4);
        vecs[15] = mk(PH_MOVE,  3'd1, 0, 1, 0, 16, 5);
        vecs[16] = mk(PH_MOVE,  3'd1, 0, 1, 0, 16, 6);
        vecs[17] = mk(PH_MOVE,  3'd1, 0, 1, 0, 16, 7);
        vecs[18] = mk(PH_MOVE,  3'd1, 0, 1, 0, 16, 7);
        vecs[19] = mk(PH_MOVE,  3'd1, 1, 1, 1, 15, 7);
        vecs[20] = mk(PH_ADD,   3'd7, 0, 0, 0, 18, 3);
        vecs[21] = mk(PH_MOVE,  3'd7, 0, 1, 0, 18, 4);
        vecs[22] = mk(PH_MOVE,  3'd7, 0, 1, 0, 18, 5);
        vecs[23] = mk(PH_MOVE,  3'd7, 0, 1, 0, 18, 6);
        vecs[24] = mk(PH_MOVE,  3'd7, 0, 1, 0, 18, 6);

        // Reset state
        tick(1'b1, PH_CHECK, 3'd0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, PH_CHECK, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("rst_board", bus.board, 256'h0);
        chk("rst_shift", bus.shift, 256'h0);
        chk("rst_stop", bus.stop, 256'h0);
        chk("rst_go", bus.gameOver, 256'h0);
        chk("rst_lines", bus.lines, 256'h0);
        chk("rst_row", bus.piece_row, 256'd18);
        chk("rst_col", bus.piece_col, 256'd3);

        // Spawn and lateral-move vectors
        for (int i = 0; i < 25; i++) begin
            tick(1'b0, vecs[i].ph, vecs[i].sel, vecs[i].l, vecs[i].r, vecs[i].d);
            $display("vec %0d ph=%0d l=%0b r=%0b d=%0b -> row=%0d col=%0d", i, vecs[i].ph,
                     vecs[i].l, vecs[i].r, vecs[i].d, bus.piece_row, bus.piece_col);
            chk($sformatf("vec%0d_row", i), bus.piece_row, vecs[i].row);
            chk($sformatf("vec%0d_col", i), bus.piece_col, vecs[i].col);
            chk($sformatf("vec%0d_stop", i), bus.stop, vecs[i].stop);
            chk($sformatf("vec%0d_go", i), bus.gameOver, vecs[i].go);
        end

        // O piece falls 18 rows, lands on the 19th tick, then locks
        tick(1'b1, PH_CHECK, 3'd0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, PH_ADD, 3'd1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 18; i++)
            tick(1'b0, PH_MOVE, 3'd1, 1'b0, 1'b0, 1'b1);
        chk("fall_row", bus.piece_row, 256'd0);
        chk("fall_stop", bus.stop, 256'h1);
        tick(1'b0, PH_MOVE, 3'd1, 1'b0, 1'b0, 1'b1);
        chk("land_stop", bus.stop, 256'h0);
        chk("land_row", bus.piece_row, 256'd0);
        tick(1'b0, PH_WRITE, 3'd1, 1'b0, 1'b0, 1'b0);
        $display("lock O: board=%0h", bus.board);
        chk("lock_board", bus.board, 256'hC030);
        chk("lock_go", bus.gameOver, 256'h0);

        // Rows 0 and 2 full, row 1 and 3 partial; collapse one row per SHIFT entry
        tick(1'b1, PH_CHECK, 3'd0, 1'b0, 1'b0, 1'b0);
        place(0, 0, 0); place(0, 4, 0); place(1, 7, 0);
        place(0, 0, 2); place(0, 4, 2); place(1, 7, 2);
        expb = 256'h3FF | (256'h300 << 10) | (256'h3FF << 20) | (256'h300 << 30);
        chk("pre_board", bus.board, expb);
        tick(1'b0, PH_CHECK, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("chk1_shift", bus.shift, 256'h5);
        tick(1'b0, PH_SHIFT, 3'd0, 1'b0, 1'b0, 1'b0);
        $display("shift 1: board=%0h lines=%0d", bus.board, bus.lines);
        expb = 256'h300 | (256'h3FF << 10) | (256'h300 << 20);
        chk("sh1_board", bus.board, expb);
        chk("sh1_lines", bus.lines, 256'd1);
        chk("sh1_shift", bus.shift, 256'h0);
        tick(1'b0, PH_SHIFT, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("sh1_hold", bus.board, expb);
        tick(1'b0, PH_CHECK, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("chk2_shift", bus.shift, 256'h2);
        tick(1'b0, PH_SHIFT, 3'd0, 1'b0, 1'b0, 1'b0);
        expb = 256'h300 | (256'h300 << 10);
        chk("sh2_board", bus.board, expb);
        chk("sh2_lines", bus.lines, 256'd2);
        tick(1'b0, PH_CHECK, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("chk3_shift", bus.shift, 256'h0);

        // Column 4-5 stacked to row 19 blocks the spawn box
        tick(1'b1, PH_CHECK, 3'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++)
            place(1, 3, 2 * k);
        expb = '0;
        for (int r = 0; r < 20; r++)
            expb = expb | (256'h30 << (r * 10));
        chk("stack_board", bus.board, expb);
        chk("stack_go", bus.gameOver, 256'h0);
        tick(1'b0, PH_ADD, 3'd1, 1'b0, 1'b0, 1'b0);
        $display("spawn blocked: gameOver=%0b stop=%0h", bus.gameOver, bus.stop);
        chk("coll_go", bus.gameOver, 256'h1);
        chk("coll_stop", bus.stop, 256'h0);
        chk("coll_board", bus.board, expb);
        tick(1'b0, PH_MOVE, 3'd1, 1'b1, 1'b0, 1'b1);
        tick(1'b0, PH_WRITE, 3'd1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, PH_SHIFT, 3'd1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, PH_ADD, 3'd0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, PH_CHECK, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("sticky_go", bus.gameOver, 256'h1);
        chk("sticky_board", bus.board, expb);
        chk("sticky_col", bus.piece_col, 256'd3);

        // Reset wins over the first SHIFT cycle
        tick(1'b1, PH_CHECK, 3'd0, 1'b0, 1'b0, 1'b0);
        place(0, 0, 0); place(0, 4, 0); place(1, 7, 0);
        tick(1'b0, PH_CHECK, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_shift", bus.shift, 256'h1);
        tick(1'b1, PH_SHIFT, 3'd0, 1'b0, 1'b0, 1'b0);
        $display("reset mid-SHIFT: board=%0h lines=%0d shift=%0h", bus.board, bus.lines, bus.shift);
        chk("midrst_board", bus.board, 256'h0);
        chk("midrst_lines", bus.lines, 256'h0);
        chk("midrst_shift", bus.shift, 256'h0);

        // Random play against the cell model, starting from a board with full rows
        tick(1'b1, PH_CHECK, 3'd0, 1'b0, 1'b0, 1'b0);
        place(0, 0, 0); place(0, 4, 0); place(1, 7, 0);
        place(0, 0, 2); place(0, 4, 2); place(1, 7, 2);
        tick(1'b0, PH_CHECK, 3'd0, 1'b0, 1'b0, 1'b0);
        cur_ph = PH_SHIFT;
        for (int n = 0; n < 1200; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 15))
                    0, 1, 2, 3, 4, 5, 15: cur_ph = PH_MOVE;
                    6, 7:   cur_ph = PH_ADD;
                    8, 9:   cur_ph = PH_WRITE;
                    10, 11: cur_ph = PH_CHECK;
                    12, 13: cur_ph = PH_SHIFT;
                    default: begin
                        v3 = 3'($urandom_range(5, 7));
                        cur_ph = v3;
                    end
                endcase
            end
            tick($urandom_range(0, 99) == 0, cur_ph, 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            chk($sformatf("rnd%0d_board", n), bus.board, m_flat());
            chk($sformatf("rnd%0d_state", n),
                {bus.shift, bus.stop, bus.gameOver, bus.piece_row, bus.piece_col, bus.lines},
                {m_shift, m_stop, m_go, 5'(m_row), 4'(m_col), m_lines});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
